// File: rtl/seq_pattern_gen_pkg.sv
// seq_pattern_gen_pkg: state encoding and len clamp shared by the generator and its detector bench
package seq_pattern_gen_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  function automatic int clamp_len(input int len, input int max_len);
    return (len == 0 || len > max_len) ? max_len : len;
  endfunction
endpackage

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: Moore serial pattern generator, MSB-first, repeat passes with optional idle gap
// Ports: clk/rst (async active-high); i_start/i_pattern/i_len/i_repeat request a transfer while
// o_ready=1; o_out/o_valid carry the serial stream; o_done pulses one cycle after the last bit.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LEN_W      = $clog2(DATA_W + 1),
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_pattern,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [RPT_W-1:0]  i_repeat,
  output logic              o_out,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_done
);
  localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_shift, r_hold, w_aligned;
  logic [LEN_W-1:0]  r_len, r_bit, w_len;
  logic [RPT_W-1:0]  r_pass;
  logic [GAP_W-1:0]  r_gap;
  logic              w_last;
  // the pattern is stored left-aligned so the bit on the wire is always the register MSB
  always_comb begin
    w_len     = LEN_W'(clamp_len(int'(i_len), DATA_W));
    w_aligned = i_pattern << (DATA_W - int'(w_len));
    w_last    = r_bit == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = i_start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next = !w_last ? ST_SHIFT : r_pass == '0 ? ST_DONE : GAP_CYCLES > 0 ? ST_GAP : ST_SHIFT;
      ST_GAP:   w_next = r_gap == '0 ? ST_SHIFT : ST_GAP;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_shift <= '0;
      r_hold  <= '0;
      r_len   <= '0;
      r_bit   <= '0;
      r_pass  <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_hold  <= w_aligned;
          r_shift <= w_aligned;
          r_len   <= w_len;
          r_bit   <= w_len - 1'b1;
          r_pass  <= i_repeat;
        end
        ST_SHIFT: if (!w_last) begin
          r_shift <= r_shift << 1;
          r_bit   <= r_bit - 1'b1;
        end else if (r_pass != '0) begin
          r_shift <= r_hold;
          r_bit   <= r_len - 1'b1;
          r_pass  <= r_pass - 1'b1;
          r_gap   <= GAP_W'(GAP_CYCLES - 1);
        end
        ST_GAP: r_gap <= r_gap - 1'b1;
        default: ;
      endcase
    end
  always_comb begin
    o_ready = r_state == ST_IDLE;
    o_valid = r_state == ST_SHIFT;
    o_done  = r_state == ST_DONE;
    o_out   = o_valid & r_shift[DATA_W-1];
  end
endmodule
